// File: rtl/major_state.sv
// Major-state sequencer for the PDP-8e core: Fetch/Defer/Execute/Halt sub-cycles and
// instruction latch. Optional build macro SINGLE_STEP_EN enables the sstep halt input.
module major_state #(
  parameter logic [3:0] F0 = 4'd0,
  parameter logic [3:0] F1 = 4'd1,
  parameter logic [3:0] F2 = 4'd2,
  parameter logic [3:0] F3 = 4'd3,
  parameter logic [3:0] D0 = 4'd4,
  parameter logic [3:0] D1 = 4'd5,
  parameter logic [3:0] D2 = 4'd6,
  parameter logic [3:0] D3 = 4'd7,
  parameter logic [3:0] E0 = 4'd8,
  parameter logic [3:0] E1 = 4'd9,
  parameter logic [3:0] E2 = 4'd10,
  parameter logic [3:0] E3 = 4'd11,
  parameter logic [3:0] H0 = 4'd12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] mdout,
  input  logic        run,
  input  logic        sstep,
  input  logic        cont,
  output logic [3:0]  state,
  output logic [0:11] instruction,
  output logic        halted,
  output logic        inst_done
);

  typedef enum logic [3:0] {
    StF0 = F0, StF1 = F1, StF2 = F2, StF3 = F3,
    StD0 = D0, StD1 = D1, StD2 = D2, StD3 = D3,
    StE0 = E0, StE1 = E1, StE2 = E2, StE3 = E3,
    StH0 = H0
  } state_e;

  state_e      state_q, state_d;
  logic [0:11] instr_q;
  logic        halted_q, halted_d;
  logic        done_q, done_d;
  logic        step_halt;

`ifdef SINGLE_STEP_EN
  assign step_halt = sstep;
`else
  logic unused_sstep;
  assign unused_sstep = sstep;
  assign step_halt    = 1'b0;
`endif

  logic [2:0] op;
  logic       ind;
  logic       is_hlt;
  logic       ends_at_f3;
  state_e     eoi_state;

  assign op     = instr_q[0:2];
  assign ind    = instr_q[3];
  assign is_hlt = (instr_q[0:3] == 4'b1111) && instr_q[10] && !instr_q[11];
  // JMP direct, IOT, OPR (including HLT) finish without defer or execute.
  assign ends_at_f3 = is_hlt || (op >= 3'd6) || (op == 3'd5 && !ind);
  assign eoi_state  = (!run || step_halt) ? StH0 : StF0;

  always_comb begin
    state_d = StH0;
    unique case (state_q)
      StF0: state_d = StF1;
      StF1: state_d = StF2;
      StF2: state_d = StF3;
      StF3: begin
        if (is_hlt)                     state_d = StH0;
        else if (op <= 3'd5 && ind)     state_d = StD0;
        else if (op <= 3'd4)            state_d = StE0;
        else                            state_d = eoi_state;
      end
      StD0: state_d = StD1;
      StD1: state_d = StD2;
      StD2: state_d = StD3;
      StD3: state_d = (op == 3'd5) ? eoi_state : StE0;
      StE0: state_d = StE1;
      StE1: state_d = StE2;
      StE2: state_d = StE3;
      StE3: state_d = eoi_state;
      StH0: state_d = cont ? StF0 : StH0;
      default: state_d = StH0;
    endcase
  end

  // Instruction is already latched by the time F3 is entered, so the last-cycle flag
  // can be registered alongside the state it belongs to.
  always_comb begin
    done_d   = 1'b0;
    halted_d = (state_d == StH0);
    unique case (state_d)
      StF3:    done_d = ends_at_f3;
      StD3:    done_d = (op == 3'd5);
      StE3:    done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StH0;
      instr_q  <= 12'o0000;
      halted_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      done_q   <= done_d;
      if (state_q == StF1) instr_q <= mdout;
    end
  end

  assign state       = state_q;
  assign instruction = instr_q;
  assign halted      = halted_q;
  assign inst_done   = done_q;

endmodule

// File: doc/major_state.md
# major_state

Major-state sequencer for the PDP-8e core. Generates the Fetch (F0–F3), Defer (D0–D3), Execute (E0–E3) and Halt (H0) state code. Latches the instruction word from memory data during fetch. Sits directly upstream of the accumulator block: its `state` and `instruction` outputs drive the `ac` block's `state` and `instruction` inputs.

## Interface
- F0..F3 (parameter): 4'd0..4'd3. Fetch sub-cycles.
- D0..D3 (parameter): 4'd4..4'd7. Defer sub-cycles.
- E0..E3 (parameter): 4'd8..4'd11. Execute sub-cycles.
- H0 (parameter): 4'd12. Halt.
- These encodings are shared with the other blocks through the common parameters include.
- clk (input, 1): single system clock. All state changes on the rising edge.
- reset (input, 1): asynchronous, active-low reset.
- mdout (input, [0:11]): memory read data, PDP-8 bit order, bit 0 is the MSB.
- run (input, 1): level. Low requests a halt at the next instruction boundary.
- sstep (input, 1): level. High halts after every instruction.
- cont (input, 1): one-cycle pulse. Leaves H0.
- state (output, [3:0]): current major/minor state.
- instruction (output, [0:11]): latched instruction word.
- halted (output, 1): high when state == H0.
- inst_done (output, 1): one-cycle pulse on the final sub-cycle of each instruction.

## Operation
Reset values:
- state = H0
- instruction = 12'o0000
- halted = 1
- inst_done = 0

Fetch:
- F0→F1→F2→F3 unconditionally.
- On the rising edge with state == F1: instruction <= mdout. At all other times instruction holds its value.

Decode at F3, using op = instruction[0:2], ind = instruction[3]:
- op ≤ 5 and ind = 1 → D0.
- op ≤ 4 and ind = 0 → E0.
- op = 5 (JMP) and ind = 0 → end of instruction.
- op = 6 (IOT) or op = 7 (OPR) → end of instruction.
- HLT (instruction[0:3] = 4'b1111, instruction[11] = 0, instruction[10] = 1) → H0 unconditionally. This takes priority over run, sstep and the normal end-of-instruction path.

Other sequencing:
- Defer: D0→D1→D2→D3. At D3: JMP → end of instruction; op ≤ 4 → E0.
- Execute: E0→E1→E2→E3. E3 → end of instruction.
- End of instruction (exit of F3, D3 or E3): next state is F0, or H0 if run = 0 or sstep = 1.
- inst_done is high during the cycle whose exit is the end of instruction, including the HLT exit from F3.
- H0: stays in H0 until cont = 1 is sampled, then goes to F0. run is ignored in H0, so cont with run = 0 executes exactly one instruction and then halts.
- Unused codes 13–15 → H0 on the next edge.

## Timing
- Each sub-state lasts exactly one clock.
- Instruction cycle lengths: no defer, no execute = 4 clocks; execute only = 8; defer + execute = 12; defer + JMP = 8.
- instruction is valid from the first cycle of F2 and is stable until the next F1 edge.
- halted and inst_done are registered outputs, aligned with state.
- Reset asserted mid-cycle: all outputs take their reset values immediately, with no clock needed. Deassertion is synchronized by the first rising edge.
- cont pulse outside H0: ignored.
- run is sampled only at instruction boundaries. Toggling run mid-instruction has no effect until the boundary.

## Configuration
- SINGLE_STEP_EN
  - Defined: sstep behaves as described above.
  - Undefined: the sstep port still exists but is ignored, and end-of-instruction halts depend only on run and HLT.
  - All other behaviour is identical in both builds.

## Test plan
- Reset low, then high, with run = 1, then a cont pulse. Required: state = H0 and halted = 1 during reset; after cont, state steps F0,F1,F2,F3 on consecutive clocks.
- mdout = 12'o7240 (CLA CMA) during F1. Required: instruction = 12'o7240 in F2; 4-clock cycle; inst_done high in F3; next state F0.
- mdout = 12'o1410 (TAD indirect). Required: F0–F3, D0–D3, E0–E3, then F0; 12 clocks; inst_done only in E3.
- mdout = 12'o5000 (JMP direct), then 12'o5400 (JMP indirect). Required: 4 clocks, then 8 clocks (F then D, no E).
- mdout = 12'o7402 (HLT) with run = 1. Required: F3 → H0, halted = 1; a single cont pulse resumes at F0.
- With SINGLE_STEP_EN defined, sstep = 1 and mdout = 12'o7200: H0 after every instruction, each cont pulse runs exactly one instruction. Without the macro, the same stimulus runs continuously.
